// File: rtl/bcd_text_pkg.sv
// bcd_text_pkg: shared constants and FSM encoding for the BCD text emitter.
//   ASCII_ZERO  - character for digit 0 (digits map to ASCII_ZERO + d)
//   ASCII_DOT   - decimal point character
//   ASCII_QMARK - substitute for an illegal BCD nibble (A..F)
//   emit_state_e - IDLE / EMIT / DONE controller states
package bcd_text_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } emit_state_e;

endpackage

// File: rtl/bcd_text_emitter_if.sv
// bcd_text_emitter_if: character write channel towards the overlay RAM writer.
//   char_valid - char_data/char_addr are valid (driven by master)
//   char_ready - downstream accepts when high together with char_valid
//   char_data  - ASCII character
//   char_addr  - character RAM address
interface bcd_text_emitter_if #(
  parameter int ADDR_W = 5
) ();

  logic              char_valid;
  logic              char_ready;
  logic [7:0]        char_data;
  logic [ADDR_W-1:0] char_addr;

  modport master (
    output char_valid,
    output char_data,
    output char_addr,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_data,
    input  char_addr,
    output char_ready
  );

endinterface

// File: rtl/bcd_digit_to_ascii.sv
// bcd_digit_to_ascii: combinational BCD nibble to ASCII conversion.
//   digit - BCD nibble; 0..9 are legal
//   ascii - 8'h30 + digit for legal digits, '?' for A..F
module bcd_digit_to_ascii
  import bcd_text_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  // Map legal digits onto '0'..'9'; anything else is flagged visibly as '?'.
  always_comb begin
    if (digit <= 4'd9) begin
      ascii = ASCII_ZERO + {4'b0000, digit};
    end else begin
      ascii = ASCII_QMARK;
    end
  end

endmodule

// File: rtl/bcd_text_emitter.sv
// bcd_text_emitter: renders a packed BCD count as an ASCII string with leading
// zero blanking and an optional decimal point, one character per transfer.
//   clock, reset_n - system clock, asynchronous active-low reset
//   bcd_in         - packed BCD value, nibble 0 least significant
//   start          - single-cycle request to snapshot bcd_in and emit
//   busy           - emission in progress
//   done           - one-cycle pulse after the last character transfer
//   char_if        - valid/ready character channel (data + address)
module bcd_text_emitter
  import bcd_text_pkg::*;
#(
  parameter int         DIGITS      = 6,
  parameter int         FRAC_DIGITS = 3,
  parameter logic [7:0] BLANK_CHAR  = 8'h20,
  parameter int         ADDR_W      = 5,
  parameter int         BASE_ADDR   = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  bcd_text_emitter_if.master    char_if
);

  localparam int LEN     = DIGITS + ((FRAC_DIGITS > 0) ? 1 : 0);
  localparam int IDX_W   = $clog2(LEN + 1);
  localparam int DIG_W   = $clog2(DIGITS);
  // String position of the '.' (most significant character is position 0).
  localparam int DOT_POS = DIGITS - FRAC_DIGITS;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LEN - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

  emit_state_e          state_q, state_d;
  logic [4*DIGITS-1:0]  snap_q, snap_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 nz_q, nz_d;      // a non-zero digit has already been emitted
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic [7:0]           data_q, data_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;

  logic                 load_s;
  logic [IDX_W-1:0]     pos_s;
  logic [4*DIGITS-1:0]  src_s;
  logic                 nz_base_s;
  logic                 dot_s;
  int                   dig_s;
  logic [DIG_W-1:0]     dig_sel_s;
  logic [3:0]           nib_s;
  logic                 blank_s;
  logic [7:0]           ascii_s;
  logic [3:0]           nibs_s [DIGITS];

  // At start the character is rendered straight from bcd_in, since the
  // snapshot register only holds it from the following cycle.
  always_comb begin
    load_s    = 1'b0;
    pos_s     = '0;
    src_s     = snap_q;
    nz_base_s = nz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_s    = 1'b1;
          src_s     = bcd_in;
          nz_base_s = 1'b0;
        end else begin
          load_s    = 1'b0;
        end
      end
      EMIT: begin
        if (valid_q && char_if.char_ready && (idx_q != LAST_IDX)) begin
          load_s = 1'b1;
          pos_s  = idx_q + IDX_W'(1);
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  genvar g;
  for (g = 0; g < DIGITS; g++) begin : g_nib
    assign nibs_s[g] = src_s[4*g+3 : 4*g];
  end

  // Translate a string position into either the '.' or a digit index.
  always_comb begin
    dot_s = 1'b0;
    dig_s = 0;
    if ((FRAC_DIGITS > 0) && (int'(pos_s) == DOT_POS)) begin
      dot_s = 1'b1;
    end else if ((FRAC_DIGITS > 0) && (int'(pos_s) > DOT_POS)) begin
      dig_s = DIGITS - int'(pos_s);
    end else begin
      dig_s = DIGITS - 1 - int'(pos_s);
    end
    dig_sel_s = DIG_W'(dig_s);
    if ((dig_s >= 0) && (dig_s < DIGITS)) begin
      nib_s = nibs_s[dig_sel_s];
    end else begin
      nib_s = 4'd0;
    end
    // Only integer digits above the units position can ever be blanked.
    blank_s = !dot_s && (nib_s == 4'd0) && !nz_base_s && (dig_s > FRAC_DIGITS);
  end

  bcd_digit_to_ascii u_digit (
    .digit (nib_s),
    .ascii (ascii_s)
  );

  // Controller next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    nz_d    = nz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          snap_d  = bcd_in;
          idx_d   = '0;
          busy_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (valid_q && char_if.char_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = EMIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
    if (load_s) begin
      if (dot_s) begin
        data_d = ASCII_DOT;
      end else if (blank_s) begin
        data_d = BLANK_CHAR;
      end else begin
        data_d = ascii_s;
      end
      addr_d = BASE_A + ADDR_W'(pos_s);
      nz_d   = nz_base_s | (!dot_s && (nib_s != 4'd0));
    end else begin
      nz_d   = nz_d;
    end
  end

  // State and output registers; reset abandons any partial string.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      nz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      addr_q  <= BASE_A;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      nz_q    <= nz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign char_if.char_valid = valid_q;
  assign char_if.char_data  = data_q;
  assign char_if.char_addr  = addr_q;

endmodule

// File: tb/tb_bcd_text_emitter.sv
// Bench for bcd_text_emitter: a string-level reference model plus literal
// expectations, with a default instance and a FRAC_DIGITS=0 instance.
module tb_bcd_text_emitter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [23:0] bcd_in, bcd0;
  logic        start, start0;
  logic        busy, done, busy0, done0;

  int total = 0;
  int bad   = 0;

  bcd_text_emitter_if #(.ADDR_W(5)) cif  ();
  bcd_text_emitter_if #(.ADDR_W(5)) cif0 ();

  bcd_text_emitter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bcd_in  (bcd_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .char_if (cif)
  );

  bcd_text_emitter #(.FRAC_DIGITS(0)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bcd_in  (bcd0),
    .start   (start0),
    .busy    (busy0),
    .done    (done0),
    .char_if (cif0)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference rendering, first character in the most significant byte so the
  // result compares directly with a string literal.
  function automatic logic [55:0] render(input logic [23:0] v, input int frac);
    logic [7:0]  s [8];
    logic [3:0]  nib;
    logic [55:0] r;
    int p, len;
    bit lead;
    p = 0; lead = 1'b1; r = '0;
    for (int k = 5; k >= 0; k--) begin
      nib = v[k*4 +: 4];
      if (nib != 4'd0 || k <= frac) lead = 1'b0;
      s[p] = lead ? 8'h20 : ((nib <= 4'd9) ? (8'h30 + {4'd0, nib}) : 8'h3F);
      p++;
      if (frac > 0 && k == frac) begin
        s[p] = 8'h2E;
        p++;
      end
    end
    len = p;
    for (int i = 0; i < len; i++) r[(len-1-i)*8 +: 8] = s[i];
    return r;
  endfunction

  // Transaction-level model of the default instance.
  int          m_mode;       // 0 idle, 1 emitting, 2 done pulse
  int          m_idx;
  logic [55:0] m_str;
  int          cyc = 0;
  int          start_edge = 0, done_edge = 0;
  int          xfers = 0, dones = 0, xfers0 = 0, dones0 = 0;
  logic [55:0] cap = '0, cap0 = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= 0;
      m_idx  <= 0;
    end else begin
      case (m_mode)
        0: if (start) begin
             m_str      <= render(bcd_in, 3);
             m_idx      <= 0;
             m_mode     <= 1;
             start_edge <= cyc;
           end
        1: if (cif.char_ready) begin
             if (m_idx == 6) m_mode <= 2;
             else            m_idx  <= m_idx + 1;
           end
        default: m_mode <= 0;
      endcase
    end
  end

  // Collect accepted characters and done pulses from both instances.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset_n) begin
      if (cif.char_valid && cif.char_ready) begin
        cap   <= {cap[47:0], cif.char_data};
        xfers <= xfers + 1;
      end
      if (done) begin
        dones     <= dones + 1;
        done_edge <= cyc;
      end
      if (cif0.char_valid && cif0.char_ready) begin
        cap0   <= {cap0[47:0], cif0.char_data};
        xfers0 <= xfers0 + 1;
      end
      if (done0) dones0 <= dones0 + 1;
    end
  end

  // Per-cycle comparison of the default instance against the model.
  always @(negedge clock) begin
    if (reset_n) begin
      if (m_mode == 1)
        check("emit", {busy, done, cif.char_valid, cif.char_data, cif.char_addr},
              {1'b1, 1'b0, 1'b1, m_str[(6-m_idx)*8 +: 8], 5'(m_idx)});
      else
        check("flags", {busy, done, cif.char_valid}, {1'b0, (m_mode == 2), 1'b0});
    end
  end

  task automatic run_a(input logic [23:0] v, input logic [55:0] exp_str,
                       input bit toggle, input string nm);
    int x0, d0;
    x0 = xfers; d0 = dones;
    bcd_in = v; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 60 && dones == d0; i++) begin
      if (toggle) cif.char_ready = ~cif.char_ready;
      @(negedge clock);
    end
    cif.char_ready = 1'b1;
    repeat (3) @(negedge clock);
    check({nm, "_str"},   cap, exp_str);
    check({nm, "_xfers"}, xfers - x0, 7);
    check({nm, "_dones"}, dones - d0, 1);
    if (!toggle) check({nm, "_latency"}, done_edge - start_edge, 8);
  endtask

  task automatic run_b(input logic [23:0] v, input logic [47:0] exp_str, input string nm);
    int x0, d0;
    x0 = xfers0; d0 = dones0;
    bcd0 = v; start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    for (int i = 0; i < 40 && dones0 == d0; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    check({nm, "_str"},   cap0[47:0], exp_str);
    check({nm, "_xfers"}, xfers0 - x0, 6);
    check({nm, "_dones"}, dones0 - d0, 1);
  endtask

  initial begin
    int x0, d0;
    reset_n = 1'b0; start = 1'b0; start0 = 1'b0;
    bcd_in = 24'h0; bcd0 = 24'h0;
    cif.char_ready = 1'b1; cif0.char_ready = 1'b1;
    #1;
    check("reset_a", {busy, done, cif.char_valid, cif.char_data, cif.char_addr}, 64'h0);
    check("reset_b", {busy0, done0, cif0.char_valid, cif0.char_data, cif0.char_addr}, 64'h0);

    // Pin the reference model to hand-derived strings.
    check("model_1234", render(24'h001234, 3), "  1.234");
    check("model_qm",   render(24'h00A012, 3), "  ?.012");
    check("model_f0",   render(24'h000050, 0), "    50");

    #20 reset_n = 1'b1;
    @(negedge clock);

    run_a(24'h001234, "  1.234", 1'b0, "r1234");
    run_a(24'h000000, "  0.000", 1'b0, "rzero");
    run_a(24'h999999, "999.999", 1'b0, "r9s");
    run_a(24'h00A012, "  ?.012", 1'b0, "rqm");
    run_a(24'h123456, "123.456", 1'b1, "rtoggle");

    // Restart attempt with a new value while busy must be ignored.
    x0 = xfers; d0 = dones;
    bcd_in = 24'h001234; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    bcd_in = 24'h999999; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 40 && dones == d0; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    check("restart_str",   cap, "  1.234");
    check("restart_xfers", xfers - x0, 7);
    check("restart_dones", dones - d0, 1);

    // Asynchronous reset in the middle of a string.
    x0 = xfers;
    bcd_in = 24'h123456; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 20 && (xfers - x0) < 3; i++) @(negedge clock);
    check("pre_rst_xfers", xfers - x0, 3);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async", {busy, done, cif.char_valid, cif.char_data, cif.char_addr}, 64'h0);
    d0 = dones;
    repeat (3) @(negedge clock);
    check("rst_no_done", dones - d0, 0);
    reset_n = 1'b1;
    @(negedge clock);
    run_a(24'h000120, "  0.120", 1'b0, "after_rst");

    // Instance without a decimal point.
    run_b(24'h000050, "    50", "f0_50");
    run_b(24'h000000, "     0", "f0_zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
